zigzag_serializer: RTL
======================

# zigzag_serializer

Converts each quantized 8x8 coefficient block into a serial stream of 64 coefficients in JPEG zigzag order. It sits directly downstream of the Y/Cb/Cr quantizers. It accepts a whole block in parallel on the quantizer's `out_enable` strobe. It emits one coefficient per accepted handshake toward the run-length/entropy stage. A two-entry ping-pong buffer lets one block be captured while the previous block is still draining under backpressure.

## Interface
- `COEFF_W`, default 11: signed coefficient width.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_enable  in  1`: block strobe from the quantizer (`out_enable`).
- `in_block  in  COEFF_W x [8][8] signed`: quantized block, indexed [row][col].
- `in_ready  out  1`: at least one buffer is free.
- `coeff  out  COEFF_W signed`: current zigzag coefficient.
- `coeff_idx  out  6`: zigzag position 0..63; 0 is the DC coefficient.
- `coeff_last  out  1`: high when `coeff_idx == 63`.
- `coeff_valid  out  1`: `coeff` is valid.
- `coeff_ready  in  1`: downstream accepts.
- `overflow  out  1`: sticky; set when a block is dropped.

## Operation
- Storage: two buffers of 64 x `COEFF_W` each. Pointers are `wr_sel` and `rd_sel` (1 bit each). `full_cnt` ranges 0..2.
- Capture: when `in_enable && in_ready` at a rising edge, the whole `in_block` is written into buffer `wr_sel`. `wr_sel` toggles and `full_cnt` increments.
- Drop: when `in_enable && !in_ready`, the block is discarded and `overflow` is set. `overflow` clears only on `rst`.
- `in_ready = (full_cnt != 2)`. It is a function of registered state only; a drain completing in the same cycle does not raise it.
- Output FSM:
  - IDLE: `coeff_valid = 0`. Go to STREAM when `full_cnt != 0`.
  - STREAM: `coeff_valid = 1`. `coeff = buf[rd_sel][ZZ_ROW[idx]][ZZ_COL[idx]]`. On `coeff_valid && coeff_ready`, `idx` increments.
  - On a handshake at `idx == 63`: `idx` returns to 0, `rd_sel` toggles and `full_cnt` decrements. The FSM stays in STREAM if another buffer is full after the update, otherwise it goes to IDLE.
- Simultaneous capture and final drain in one cycle: `full_cnt` is unchanged. The write and read never target the same buffer.
- When `coeff_ready` is low, `coeff`, `coeff_idx` and `coeff_last` hold stable.
- Zigzag order is the standard JPEG order. It starts (0,0),(0,1),(1,0),(2,0),(1,1),(0,2),(0,3),(1,2),… and ends (7,7).
- No arithmetic is performed: values pass through bit-exact.
- Reset values: `full_cnt=0`, `wr_sel=0`, `rd_sel=0`, `idx=0`, FSM=IDLE. Outputs reset to `coeff_valid=0`, `coeff_last=0`, `coeff_idx=0`, `in_ready=1`, `overflow=0`. `coeff` is don't-care while invalid; buffer contents are not reset.

## Timing
- When capture occurs at edge N from an empty state, `coeff_valid` is high in the cycle after edge N with `coeff_idx=0`.
- With `coeff_ready` held high, a block drains in exactly 64 cycles.
- A block already waiting follows with no bubble: index 63 of block A is followed next cycle by index 0 of block B.
- Maximum sustained input rate is one block per 64 cycles. Two back-to-back strobes are accepted (both buffers) only if `full_cnt` is 0 at the first strobe.
- Reset asserted mid-stream: at the next edge all state returns to reset values. Partially streamed and buffered blocks are lost, and `coeff_valid` is low in the following cycle.

## Structure
- Shared package `jpeg_zigzag_pkg` holds:
  - `COEFF_W_DEFAULT = 11`.
  - Constant arrays `ZZ_ROW[64]` and `ZZ_COL[64]` (3-bit each).
  - The FSM enum `zz_state_t {ZZ_IDLE, ZZ_STREAM}`.
- One sub-module, `zigzag_buffer`, holds the two-entry 64-coefficient storage. It provides a parallel write port (buffer select plus block) and a single read port (buffer select, row, column). The top level holds the counters, pointers and FSM.

## Test plan
- Ramp block with `in_block[r][c] = 8r+c`, `coeff_ready=1` → outputs 0,1,8,16,9,2,3,10,17,24,…,63. `coeff_last` is high only at the 64th output, and `coeff_valid` starts the cycle after the strobe.
- Signed extremes: `in_block[0][0]=-1024`, `in_block[7][7]=1023`, all others -1 → `coeff` equals -1024 at idx 0, 1023 at idx 63, and -1 elsewhere, bit-exact.
- Backpressure: deassert `coeff_ready` for 5 cycles at idx 10 → `coeff`/`coeff_idx` hold at idx 10 and the stream then resumes with no loss or duplication.
- Back-to-back blocks A (all 1) and B (all 2) strobed 2 cycles apart → 64 ones then 64 twos, no gap, `in_ready` low while both buffers are full.
- Overflow: with `coeff_ready=0`, strobe three blocks → third is dropped, `overflow=1` and stays set. After releasing `coeff_ready`, exactly 128 coefficients are emitted.
- Reset at idx 30 of block A with block B queued → `coeff_valid=0` and `in_ready=1` after the reset edge, and `overflow=0`. A fresh ramp block then streams correctly from idx 0.

Source files
------------

// File: rtl/jpeg_zigzag_pkg.sv
// Shared definitions for the zigzag serializer: coefficient width default,
// the JPEG zigzag scan tables and the output FSM state type.
package jpeg_zigzag_pkg;

  localparam int COEFF_W_DEFAULT = 11;

  // Row of the natural-order coefficient visited at each zigzag position.
  localparam logic [2:0] ZZ_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
    3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
  };

  // Column of the natural-order coefficient visited at each zigzag position.
  localparam logic [2:0] ZZ_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
    3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
    3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
  };

  typedef enum logic {
    ZZ_IDLE,
    ZZ_STREAM
  } zz_state_t;

endpackage

// File: rtl/zigzag_buffer.sv
// Two-entry ping-pong storage for 8x8 coefficient blocks: a whole block is
// written in one cycle, and one coefficient at a time is read back by row/col.
module zigzag_buffer
  import jpeg_zigzag_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic signed [COEFF_W-1:0] wr_block [8][8],
  input  logic                      rd_sel,
  input  logic [2:0]                rd_row,
  input  logic [2:0]                rd_col,
  output logic signed [COEFF_W-1:0] rd_data
);

  logic signed [COEFF_W-1:0] mem [2][8][8];

  // Capture the full block into the selected entry; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          mem[wr_sel][r][c] <= wr_block[r][c];
        end
      end
    end
  end

  assign rd_data = mem[rd_sel][rd_row][rd_col];

endmodule

// File: rtl/zigzag_serializer.sv
// Accepts quantized 8x8 blocks in parallel and streams them out one
// coefficient per handshake in JPEG zigzag order, double-buffered so a new
// block can be captured while the previous one drains.
module zigzag_serializer
  import jpeg_zigzag_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_enable,
  input  logic signed [COEFF_W-1:0] in_block [8][8],
  output logic                      in_ready,
  output logic signed [COEFF_W-1:0] coeff,
  output logic [5:0]                coeff_idx,
  output logic                      coeff_last,
  output logic                      coeff_valid,
  input  logic                      coeff_ready,
  output logic                      overflow
);

  zz_state_t  state;
  zz_state_t  state_next;
  logic [5:0] idx;
  logic       wr_sel;
  logic       rd_sel;
  logic [1:0] full_cnt;
  logic [1:0] full_cnt_next;
  logic       capture;
  logic       drain;

  // in_ready depends only on registered occupancy, so a drain finishing in
  // the same cycle does not let an extra block in.
  assign in_ready   = (full_cnt != 2'd2);
  assign coeff_idx  = idx;
  assign coeff_last = (idx == 6'd63);

  zigzag_buffer #(
    .COEFF_W (COEFF_W)
  ) u_buffer (
    .clk      (clk),
    .wr_en    (capture),
    .wr_sel   (wr_sel),
    .wr_block (in_block),
    .rd_sel   (rd_sel),
    .rd_row   (ZZ_ROW[idx]),
    .rd_col   (ZZ_COL[idx]),
    .rd_data  (coeff)
  );

  // Occupancy bookkeeping: a capture and a final drain in the same cycle cancel.
  always_comb begin
    capture       = in_enable && in_ready;
    drain         = (state == ZZ_STREAM) && coeff_ready && (idx == 6'd63);
    full_cnt_next = full_cnt;
    case ({capture, drain})
      2'b10:   full_cnt_next = full_cnt + 2'd1;
      2'b01:   full_cnt_next = full_cnt - 2'd1;
      default: full_cnt_next = full_cnt;
    endcase
  end

  // Next state looks at the updated occupancy so streaming starts the cycle
  // right after a capture and continues without a bubble into a queued block.
  always_comb begin
    state_next  = state;
    coeff_valid = 1'b0;
    case (state)
      ZZ_IDLE: begin
        if (full_cnt_next != 2'd0) state_next = ZZ_STREAM;
      end
      ZZ_STREAM: begin
        coeff_valid = 1'b1;
        if (drain && (full_cnt_next == 2'd0)) state_next = ZZ_IDLE;
      end
      default: state_next = ZZ_IDLE;
    endcase
  end

  // State, pointers, scan index and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ZZ_IDLE;
      idx      <= 6'd0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      full_cnt <= 2'd0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      full_cnt <= full_cnt_next;
      if (capture) wr_sel <= ~wr_sel;
      if (coeff_valid && coeff_ready) begin
        idx <= idx + 6'd1;
        if (idx == 6'd63) rd_sel <= ~rd_sel;
      end
      if (in_enable && !in_ready) overflow <= 1'b1;
    end
  end

endmodule
